// File: rtl/vram_sched_pkg.sv
// -----------------------------------------------------------------------------
// vram_sched_pkg
// Shared types and default geometry for the character-VRAM scheduler.
//   vram_addr_t : 12-bit VRAM character address (row*COLS + col)
//   char_t      : 8-bit character code
//   state_e     : per-cycle scheduler state (what the VRAM port did this cycle)
// The DEF_* values are the 640x480 text-mode defaults (80x30 cells of 8x16).
// -----------------------------------------------------------------------------
package vram_sched_pkg;

  localparam int DEF_COLS    = 80;
  localparam int DEF_ROWS    = 30;
  localparam int DEF_HACTIVE = 640;
  localparam int DEF_VACTIVE = 480;
  localparam int VRAM_DEPTH  = DEF_COLS * DEF_ROWS;

  typedef logic [11:0] vram_addr_t;
  typedef logic [7:0]  char_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // port unused
    RD   = 2'd1,  // display fetch issued
    WR   = 2'd2,  // host write issued
    ERR  = 2'd3   // host write dropped (address out of range)
  } state_e;

endpackage

// File: rtl/vram_sched_if.sv
// -----------------------------------------------------------------------------
// vram_sched_if
// Host write port of the character VRAM scheduler.
//   HOST_REQ   : write request, held by the host until HOST_ACK
//   HOST_ADDR  : character address row*COLS+col
//   HOST_WDATA : character code to store
//   HOST_ACK   : one-cycle pulse, request consumed
//   HOST_ERR   : one-cycle pulse with HOST_ACK when the write was dropped
// master = host side, slave = scheduler side.
// -----------------------------------------------------------------------------
interface vram_sched_if;
  import vram_sched_pkg::*;

  logic       HOST_REQ;
  vram_addr_t HOST_ADDR;
  char_t      HOST_WDATA;
  logic       HOST_ACK;
  logic       HOST_ERR;

  modport master (
    output HOST_REQ, HOST_ADDR, HOST_WDATA,
    input  HOST_ACK, HOST_ERR
  );

  modport slave (
    input  HOST_REQ, HOST_ADDR, HOST_WDATA,
    output HOST_ACK, HOST_ERR
  );

endinterface

// File: rtl/vram_addr_calc.sv
// -----------------------------------------------------------------------------
// vram_addr_calc
// Combinational decode of the sync-generator counters into a display fetch.
//   hcnt_i       : horizontal pixel counter
//   vcnt_i       : vertical line counter
//   fetch_addr_o : (vcnt>>4)*COLS + (hcnt>>3)
//   fetch_slot_o : first pixel of a visible character cell
// -----------------------------------------------------------------------------
module vram_addr_calc
  import vram_sched_pkg::*;
#(
  parameter int COLS    = DEF_COLS,
  parameter int HACTIVE = DEF_HACTIVE,
  parameter int VACTIVE = DEF_VACTIVE
) (
  input  logic [9:0] hcnt_i,
  input  logic [9:0] vcnt_i,
  output vram_addr_t fetch_addr_o,
  output logic       fetch_slot_o
);

  vram_addr_t row;
  vram_addr_t col;
  vram_addr_t row_base;

  assign row = {6'b0, vcnt_i[9:4]};
  assign col = {5'b0, hcnt_i[9:3]};

  // 80 columns decomposes into 64+16, so the default build needs no multiplier.
  if (COLS == 80) begin : g_shift_add
    assign row_base = (row << 6) + (row << 4);
  end else begin : g_const_mul
    assign row_base = row * vram_addr_t'(COLS);
  end

  assign fetch_addr_o = row_base + col;
  assign fetch_slot_o = (hcnt_i[2:0] == 3'd0) &&
                        (hcnt_i < 10'(HACTIVE)) &&
                        (vcnt_i < 10'(VACTIVE));

endmodule

// File: rtl/vram_sched.sv
// -----------------------------------------------------------------------------
// vram_sched
// Shares the single-port character VRAM between the display fetch path and a
// host write port, all in the PCK domain. Display fetch has fixed priority;
// host writes fill the remaining slots.
//   PCK, RST             : pixel clock, synchronous active-high reset
//   HCNT, VCNT           : counters from the sync generator
//   host                 : host write port (vram_sched_if.slave)
//   VRAM_EN/WE/ADDR/WDATA: VRAM access strobe and command
//   VRAM_RDATA           : read data, valid one cycle after a read strobe
//   CHAR_CODE/CHAR_VLD   : fetched character, 3 PCK after the fetch slot
//   FONT_ROW             : VCNT[3:0] of the fetch slot, aligned with CHAR_CODE
// -----------------------------------------------------------------------------
module vram_sched
  import vram_sched_pkg::*;
#(
  parameter int COLS          = DEF_COLS,
  parameter int ROWS          = DEF_ROWS,
  parameter int HACTIVE       = DEF_HACTIVE,
  parameter int VACTIVE       = DEF_VACTIVE,
  parameter bit WR_BLANK_ONLY = 1'b0
) (
  input  logic             PCK,
  input  logic             RST,
  input  logic [9:0]       HCNT,
  input  logic [9:0]       VCNT,
  vram_sched_if.slave      host,
  output logic             VRAM_EN,
  output logic             VRAM_WE,
  output vram_addr_t       VRAM_ADDR,
  output char_t            VRAM_WDATA,
  input  char_t            VRAM_RDATA,
  output char_t            CHAR_CODE,
  output logic             CHAR_VLD,
  output logic [3:0]       FONT_ROW
);

  localparam int DEPTH = COLS * ROWS;

  vram_addr_t fetch_addr;
  logic       fetch_slot;
  logic       host_ok;

  state_e     state_q, state_d;
  vram_addr_t addr_q, addr_d;
  char_t      wdata_q, wdata_d;

  // Read pipeline: font row follows the fetch through RDATA to CHAR_CODE.
  logic [3:0] frow_p1_q, frow_p2_q, font_row_q;
  logic       rd_p2_q, vld_q;
  char_t      char_q;

  vram_addr_calc #(
    .COLS    (COLS),
    .HACTIVE (HACTIVE),
    .VACTIVE (VACTIVE)
  ) u_addr_calc (
    .hcnt_i       (HCNT),
    .vcnt_i       (VCNT),
    .fetch_addr_o (fetch_addr),
    .fetch_slot_o (fetch_slot)
  );

  // The request is still visible while HOST_ACK is high; without the ack
  // block the same request would be written twice.
  assign host_ok = host.HOST_REQ &&
                   (state_q != WR) && (state_q != ERR) &&
                   (!WR_BLANK_ONLY || (VCNT >= 10'(VACTIVE)));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d = IDLE;
    addr_d  = '0;
    wdata_d = '0;
    if (fetch_slot) begin
      state_d = RD;
      addr_d  = fetch_addr;
    end else if (host_ok) begin
      if (host.HOST_ADDR < vram_addr_t'(DEPTH)) begin
        state_d = WR;
        addr_d  = host.HOST_ADDR;
        wdata_d = host.HOST_WDATA;
      end else begin
        state_d = ERR;
      end
    end
  end

  always_ff @(posedge PCK) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (RST) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      frow_p1_q  <= '0;
      frow_p2_q  <= '0;
      rd_p2_q    <= 1'b0;
      vld_q      <= 1'b0;
      char_q     <= '0;
      font_row_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      frow_p1_q <= VCNT[3:0];
      frow_p2_q <= frow_p1_q;
      rd_p2_q   <= (state_q == RD);
      vld_q     <= rd_p2_q;
      if (rd_p2_q) begin
        char_q     <= VRAM_RDATA;
        font_row_q <= frow_p2_q;
      end
    end
  end

  assign VRAM_EN       = (state_q == RD) || (state_q == WR);
  assign VRAM_WE       = (state_q == WR);
  assign VRAM_ADDR     = addr_q;
  assign VRAM_WDATA    = wdata_q;
  assign host.HOST_ACK = (state_q == WR) || (state_q == ERR);
  assign host.HOST_ERR = (state_q == ERR);
  assign CHAR_CODE     = char_q;
  assign CHAR_VLD      = vld_q;
  assign FONT_ROW      = font_row_q;

endmodule

// File: tb/tb_vram_sched.sv
// -----------------------------------------------------------------------------
// tb_vram_sched
// Directed bench for vram_sched. u_dut runs with host writes allowed anywhere
// and is backed by a behavioural VRAM; u_dut_blank has WR_BLANK_ONLY=1.
// Stimulus is applied 1 ns after the rising edge; outputs are sampled at the
// same point, so each sample shows the result of the preceding edge.
// -----------------------------------------------------------------------------
module tb_vram_sched;
  import vram_sched_pkg::*;

  logic       PCK = 1'b0;
  logic       RST;
  logic [9:0] HCNT, VCNT;

  always #5 PCK = ~PCK;

  vram_sched_if h1 ();
  vram_sched_if h2 ();

  logic       en1, we1, vld1;
  vram_addr_t addr1;
  char_t      wd1, rd1, code1;
  logic [3:0] row1;

  logic       en2, we2, vld2;
  vram_addr_t addr2;
  char_t      wd2, rd2, code2;
  logic [3:0] row2;

  assign rd2 = 8'h00;

  vram_sched #(.WR_BLANK_ONLY(1'b0)) u_dut (
    .PCK (PCK), .RST (RST), .HCNT (HCNT), .VCNT (VCNT), .host (h1),
    .VRAM_EN (en1), .VRAM_WE (we1), .VRAM_ADDR (addr1), .VRAM_WDATA (wd1),
    .VRAM_RDATA (rd1), .CHAR_CODE (code1), .CHAR_VLD (vld1), .FONT_ROW (row1)
  );

  vram_sched #(.WR_BLANK_ONLY(1'b1)) u_dut_blank (
    .PCK (PCK), .RST (RST), .HCNT (HCNT), .VCNT (VCNT), .host (h2),
    .VRAM_EN (en2), .VRAM_WE (we2), .VRAM_ADDR (addr2), .VRAM_WDATA (wd2),
    .VRAM_RDATA (rd2), .CHAR_CODE (code2), .CHAR_VLD (vld2), .FONT_ROW (row2)
  );

  // Unwritten locations read back a fixed address-derived pattern.
  function automatic char_t pat(vram_addr_t a);
    return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h5A;
  endfunction

  // Behavioural VRAM behind u_dut: read data registered one cycle after strobe.
  char_t mem     [4096];
  bit    wr_flag [4096];

  always @(posedge PCK) begin
    if (en1) begin
      if (we1) begin
        mem[addr1]     <= wd1;
        wr_flag[addr1] <= 1'b1;
      end else begin
        rd1 <= wr_flag[addr1] ? mem[addr1] : pat(addr1);
      end
    end
  end

  // Expected VRAM contents, built only from what the host side asked for.
  char_t exp_data [4096];
  bit    exp_flag [4096];

  function automatic char_t exp_char(vram_addr_t a);
    return exp_flag[a] ? exp_data[a] : pat(a);
  endfunction

  function automatic logic [23:0] bus(logic en, logic we, vram_addr_t a,
                                      char_t d, logic ack, logic err);
    return {en, we, a, d, ack, err};
  endfunction

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge PCK);
    #1;
  endtask

  typedef struct {
    logic [9:0]  h;
    logic [9:0]  v;
    logic        req;
    vram_addr_t  a;
    char_t       d;
    logic [23:0] exp;  // {EN, WE, ADDR, WDATA, ACK, ERR}
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  logic [23:0] obs1;
  assign obs1 = {en1, we1, addr1, wd1, h1.HOST_ACK, h1.HOST_ERR};

  initial begin
    int n_vld, n_rd, n_wr, b2b, cur, first_cyc, last_cyc, n_ack2, n_vld2, mism;
    vram_addr_t first_addr, last_addr;
    logic prev_ack, seen_rd;

    vecs[0]  = '{10'd0,    10'd17,   1'b0, 12'd0,    8'h00, bus(1, 0, 12'd80,   8'h00, 0, 0)};
    vecs[1]  = '{10'd632,  10'd17,   1'b0, 12'd0,    8'h00, bus(1, 0, 12'd159,  8'h00, 0, 0)};
    vecs[2]  = '{10'd640,  10'd17,   1'b0, 12'd0,    8'h00, bus(0, 0, 12'd0,    8'h00, 0, 0)};
    vecs[3]  = '{10'd8,    10'd479,  1'b0, 12'd0,    8'h00, bus(1, 0, 12'd2321, 8'h00, 0, 0)};
    vecs[4]  = '{10'd8,    10'd480,  1'b0, 12'd0,    8'h00, bus(0, 0, 12'd0,    8'h00, 0, 0)};
    vecs[5]  = '{10'd8,    10'd17,   1'b1, 12'd5,    8'h41, bus(1, 0, 12'd81,   8'h00, 0, 0)};
    vecs[6]  = '{10'd9,    10'd17,   1'b1, 12'd5,    8'h41, bus(1, 1, 12'd5,    8'h41, 1, 0)};
    vecs[7]  = '{10'd3,    10'd200,  1'b1, 12'(VRAM_DEPTH), 8'h00, bus(0, 0, 12'd0, 8'h00, 1, 1)};
    vecs[8]  = '{10'd3,    10'd200,  1'b1, 12'd2399, 8'h7E, bus(1, 1, 12'd2399, 8'h7E, 1, 0)};
    vecs[9]  = '{10'd7,    10'd0,    1'b0, 12'd0,    8'h00, bus(0, 0, 12'd0,    8'h00, 0, 0)};
    vecs[10] = '{10'd0,    10'd520,  1'b1, 12'd0,    8'h33, bus(1, 1, 12'd0,    8'h33, 1, 0)};
    vecs[11] = '{10'd16,   10'd0,    1'b0, 12'd0,    8'h00, bus(1, 0, 12'd2,    8'h00, 0, 0)};
    vecs[12] = '{10'd0,    10'd479,  1'b1, 12'd4095, 8'hFF, bus(1, 0, 12'd2320, 8'h00, 0, 0)};
    vecs[13] = '{10'd1023, 10'd1023, 1'b1, 12'd4095, 8'hFF, bus(0, 0, 12'd0,    8'h00, 1, 1)};

    // ---- Reset with a request pending: no ack, all outputs low ----
    RST = 1'b1; HCNT = 10'd1; VCNT = 10'd0;
    h1.HOST_REQ = 1'b1; h1.HOST_ADDR = 12'd10; h1.HOST_WDATA = 8'h11;
    h2.HOST_REQ = 1'b0; h2.HOST_ADDR = 12'd0;  h2.HOST_WDATA = 8'h00;
    for (int k = 0; k < 3; k++) begin
      step();
      check("reset_quiet", {obs1, code1, vld1, row1}, '0);
    end
    RST = 1'b0; HCNT = 10'd2;
    step();
    check("first_ack_after_reset", obs1, bus(1, 1, 12'd10, 8'h11, 1, 0));
    exp_flag[10] = 1'b1; exp_data[10] = 8'h11;
    h1.HOST_REQ = 1'b0; HCNT = 10'd3;
    step();
    check("ack_single_cycle", obs1, bus(0, 0, 12'd0, 8'h00, 0, 0));

    // ---- Single-edge arbitration vectors, each after an idle cycle ----
    for (int i = 0; i < NV; i++) begin
      h1.HOST_REQ = 1'b0; HCNT = 10'd1; VCNT = 10'd0;
      step();
      HCNT = vecs[i].h; VCNT = vecs[i].v;
      h1.HOST_REQ = vecs[i].req; h1.HOST_ADDR = vecs[i].a; h1.HOST_WDATA = vecs[i].d;
      step();
      check($sformatf("vec%0d", i), 64'(obs1), 64'(vecs[i].exp));
      if (vecs[i].exp[23:22] == 2'b11) begin
        exp_flag[vecs[i].a] = 1'b1;
        exp_data[vecs[i].a] = vecs[i].d;
      end
    end
    h1.HOST_REQ = 1'b0; HCNT = 10'd1; VCNT = 10'd0;
    repeat (4) step();

    // ---- One visible line at VCNT=17: 80 characters from row 1 ----
    VCNT = 10'd17; n_vld = 0; n_rd = 0; first_cyc = -1; last_cyc = -1;
    seen_rd = 1'b0; first_addr = '0; last_addr = '0;
    for (int h = 0; h < 800; h++) begin
      HCNT = 10'(h);
      step();
      if (en1 && !we1) begin
        if (!seen_rd) first_addr = addr1;
        seen_rd = 1'b1; last_addr = addr1; n_rd++;
      end
      if (vld1) begin
        if (n_vld == 0) first_cyc = h + 1;
        last_cyc = h + 1;
        check($sformatf("line_char%0d", n_vld), {code1, row1},
              {exp_char(12'(80 + n_vld)), 4'd1});
        n_vld++;
      end
    end
    check("line_vld_count", n_vld, 80);
    check("line_read_count", n_rd, 80);
    check("line_first_vld_hcnt", first_cyc, 3);
    check("line_last_vld_hcnt", last_cyc, 635);
    check("line_first_read_addr", first_addr, 12'd80);
    check("line_last_read_addr", last_addr, 12'd159);

    // ---- Reset one cycle after a fetch: the read must never surface ----
    VCNT = 10'd17; HCNT = 10'd0;
    step();
    RST = 1'b1; HCNT = 10'd1;
    step();
    n_vld = vld1 ? 1 : 0;
    RST = 1'b0;
    for (int h = 2; h < 8; h++) begin
      HCNT = 10'(h);
      step();
      if (vld1) n_vld++;
    end
    check("reset_flushes_pipeline", n_vld, 0);
    repeat (4) step();

    // ---- Continuous host requests across a visible line ----
    VCNT = 10'd17; h1.HOST_REQ = 1'b1;
    cur = 0; n_wr = 0; n_rd = 0; n_vld = 0; b2b = 0; prev_ack = 1'b0;
    for (int h = 0; h < 800; h++) begin
      HCNT = 10'(h);
      h1.HOST_ADDR  = 12'(1000 + cur);
      h1.HOST_WDATA = 8'(cur) ^ 8'hA5;
      step();
      if (en1 && !we1) n_rd++;
      if (vld1) n_vld++;
      if (h1.HOST_ACK) begin
        if (prev_ack) b2b++;
        if (!h1.HOST_ERR) begin
          exp_flag[12'(1000 + cur)] = 1'b1;
          exp_data[12'(1000 + cur)] = 8'(cur) ^ 8'hA5;
          n_wr++;
        end
        cur++;
      end
      prev_ack = h1.HOST_ACK;
    end
    h1.HOST_REQ = 1'b0; HCNT = 10'd1; VCNT = 10'd0;
    step();
    check("busy_line_write_count", n_wr, 400);
    check("busy_line_reads_kept", n_rd, 80);
    check("busy_line_vld_kept", n_vld, 80);
    check("busy_line_ack_back_to_back", b2b, 0);

    // ---- WR_BLANK_ONLY: request during the visible area waits for VCNT=480 ----
    h2.HOST_REQ = 1'b1; h2.HOST_ADDR = 12'd7; h2.HOST_WDATA = 8'h99;
    n_ack2 = 0; n_vld2 = 0; VCNT = 10'd100;
    for (int h = 0; h < 16; h++) begin
      HCNT = 10'(h);
      step();
      if (h2.HOST_ACK) n_ack2++;
      if (vld2) begin
        check("blank_dut_char", {code2, row2}, {8'h00, 4'd4});
        n_vld2++;
      end
    end
    VCNT = 10'd479;
    for (int h = 795; h < 800; h++) begin
      HCNT = 10'(h);
      step();
      if (h2.HOST_ACK) n_ack2++;
    end
    check("blank_only_no_ack_visible", n_ack2, 0);
    check("blank_dut_vld_count", n_vld2, 2);
    VCNT = 10'd480; HCNT = 10'd0;
    step();
    check("blank_only_write_at_480",
          {en2, we2, addr2, wd2, h2.HOST_ACK, h2.HOST_ERR},
          bus(1, 1, 12'd7, 8'h99, 1, 0));
    h2.HOST_REQ = 1'b0; HCNT = 10'd1;
    repeat (2) step();

    // ---- Scoreboard: VRAM contents match the host's accepted writes ----
    mism = 0;
    for (int a = 0; a < 4096; a++) begin
      if (wr_flag[a] != exp_flag[a]) mism++;
      else if (exp_flag[a] && (mem[a] !== exp_data[a])) mism++;
    end
    check("vram_scoreboard", mism, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vram_sched.md
Name: vram_sched

Overview:
- Schedules the single-port character VRAM of the character-display IP in the PCK domain.
- Shares the VRAM between two users:
  - the display fetch path, driven by HCNT/VCNT from the sync generator;
  - a host write port.
- Display fetch has fixed priority. Host writes fill the free slots.
- Fetched character codes go to the font-ROM/pixel stage together with the font row index.

Parameters:
- COLS, 80, text columns (HACTIVE/8)
- ROWS, 30, text rows (VACTIVE/16)
- HACTIVE, 640, visible pixels per line
- VACTIVE, 480, visible lines per frame
- WR_BLANK_ONLY, 0, 1 = host writes only allowed while VCNT >= VACTIVE

Ports:
- PCK  in  1  pixel clock; all logic on its rising edge
- RST  in  1  reset, synchronous, active-high
- HCNT  in  10  horizontal counter from the sync generator
- VCNT  in  10  vertical counter from the sync generator
- HOST_REQ  in  1  host write request; held until HOST_ACK
- HOST_ADDR  in  12  character address, row*COLS+col
- HOST_WDATA  in  8  character code
- HOST_ACK  out  1  one-cycle pulse: request consumed
- HOST_ERR  out  1  one-cycle pulse alongside HOST_ACK when HOST_ADDR >= COLS*ROWS (write dropped)
- VRAM_EN  out  1  VRAM access strobe
- VRAM_WE  out  1  1 = write, 0 = read
- VRAM_ADDR  out  12  VRAM address
- VRAM_WDATA  out  8  VRAM write data
- VRAM_RDATA  in  8  VRAM read data, valid one cycle after a read strobe
- CHAR_CODE  out  8  fetched character code
- CHAR_VLD  out  1  CHAR_CODE valid (one-cycle pulse)
- FONT_ROW  out  4  VCNT[3:0] aligned with CHAR_CODE

Behaviour:
- Reset: every output is 0 and the fetch pipeline is cleared. A host request in flight is not acked and must stay asserted.
- Fetch slot, cycle n: asserted when HCNT[2:0]==0 && HCNT<HACTIVE && VCNT<VACTIVE.
  - Address = (VCNT>>4)*COLS + (HCNT>>3).
  - Multiply by shift-add: row*64 + row*16 for COLS=80. Generic COLS uses a constant multiply; result width 12.
- Arbitration at each edge uses the current inputs:
  1. Fetch slot: at n+1, VRAM_EN=1, VRAM_WE=0, VRAM_ADDR = fetch address.
  2. Otherwise, write is eligible when HOST_REQ && !HOST_ACK && (WR_BLANK_ONLY==0 || VCNT>=VACTIVE).
     - In range: VRAM_EN=1, VRAM_WE=1, ADDR/WDATA = host values, HOST_ACK=1.
     - Out of range: VRAM_EN=0, HOST_ACK=1, HOST_ERR=1.
  3. Otherwise VRAM_EN=0 and VRAM_WE=0.
- The !HOST_ACK term blocks re-issue of the same request in the ack cycle. Back-to-back host writes therefore take at most 1 write per 2 cycles.
- Read pipeline:
  - n+2: VRAM_RDATA valid.
  - n+3: CHAR_CODE registered and CHAR_VLD=1; FONT_ROW is VCNT[3:0] captured at n.
  - Total latency from HCNT=8c to CHAR_VLD is 3 PCK cycles.
  - Exactly COLS CHAR_VLD pulses per visible line, none in blanking.
- Worst-case host wait while reading out: 2 cycles (fetch slot plus ack-block).
  - WR_BLANK_ONLY=1 during the visible area: the request waits, with no ack, until VCNT reaches VACTIVE.
- Simultaneous fetch slot and host request: fetch wins. The host is served the next cycle (HCNT[2:0]==1).
- HCNT/VCNT wrap is handled purely by the decode; no internal frame state.
- Internal FSM, one state per cycle, derived from the registered outputs: IDLE, RD (fetch issued), WR (write issued), ERR (dropped write). Transitions follow the arbitration each cycle; there are no multi-cycle states.
- RST mid-pipeline: in-flight reads are discarded, so no CHAR_VLD appears after RST.

Decomposition:
- Package vram_sched_pkg:
  - typedef vram_addr_t (12 bits), char_t (8 bits);
  - state enum {IDLE, RD, WR, ERR};
  - localparam VRAM_DEPTH = COLS*ROWS.
- Reuse the existing VGA timing-parameter include for HACTIVE/VACTIVE defaults.
- One sub-module: vram_addr_calc. It maps HCNT/VCNT to the fetch address and fetch-slot flag, combinational, with parameter COLS.

Test Plan:
- Reset with HOST_REQ=1 → all outputs 0 and no HOST_ACK while RST=1. The first ack arrives 1 cycle after RST falls, in a non-fetch slot.
- One visible line, VCNT=17 → 80 CHAR_VLD pulses.
  - First pulse at HCNT=3, with read VRAM_ADDR=80; FONT_ROW=1.
  - Last pulse at HCNT=635, with read VRAM_ADDR=159.
- HOST_REQ held from HCNT=8, addr 5, data 0x41 → fetch at the HCNT=8 edge. At the HCNT=9 edge: VRAM_WE=1, VRAM_ADDR=5, VRAM_WDATA=0x41, HOST_ACK for 1 cycle.
- HOST_ADDR=2400 → HOST_ACK and HOST_ERR pulse together, VRAM_EN=0.
- WR_BLANK_ONLY=1, request at VCNT=100 → no ack until VCNT=480 and HCNT=0, then the write issues on that edge.
- Continuous HOST_REQ across a line → writes every 2 cycles outside fetch slots and zero fetch slots lost. A scoreboard checks that the VRAM model contents match the host writes.
